fifo_sram_pop_stream: RTL

// - Read-side adapter for the BRAM-backed synchronous FIFO (512x36, DO_REG=0).
// - Drives the FIFO's pop/empty port and delivers entries as a valid/ready stream.
// - Hides the FIFO's 1-cycle read latency and post-reset/flush unavailability.
// - Sustains 1 word/cycle with full backpressure using a 2-entry output buffer.

---
 rtl/fifo_sram_pkg.sv | 10 +
 rtl/stream_skid_buf2.sv | 49 ++++
 rtl/fifo_sram_pop_stream.sv | 60 ++++++
 3 files changed

// File: rtl/fifo_sram_pkg.sv
// fifo_sram_pkg: shared constants for the BRAM-backed FIFO and its read-side adapters
package fifo_sram_pkg;
    localparam int FIFO_RD_LATENCY     = 1;
    localparam int FIFO_MIN_RST_CYCLES = 5;
    localparam int HOLDOFF_DEFAULT     = 16;

    function automatic int holdoff_width(input int holdoff);
        return $clog2(holdoff + 1);
    endfunction
endpackage

// File: rtl/stream_skid_buf2.sv
// stream_skid_buf2: 2-entry registered valid/ready buffer with push, pop, clear and occupancy
module stream_skid_buf2
    import fifo_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);
    logic [DATA_WIDTH-1:0] r_slot0, r_slot1, w_slot0_nxt;
    logic [1:0]            r_count, w_count_nxt;
    logic                  w_pop, w_tail1;

    always_comb begin
        w_pop       = pop_i && r_count != 2'd0;
        // the pushed word lands in slot1 only when the post-pop occupancy is exactly one
        w_tail1     = push_i && ((r_count == 2'd2 && w_pop) || (r_count == 2'd1 && !w_pop));
        w_slot0_nxt = w_pop ? (r_count == 2'd2 ? r_slot1 : (push_i ? data_i : r_slot0))
                            : ((push_i && r_count == 2'd0) ? data_i : r_slot0);
        w_count_nxt = r_count + {1'b0, push_i} - {1'b0, w_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else if (clear_i) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_tail1 ? data_i : r_slot1;
            r_count <= w_count_nxt;
        end
    end

    assign valid_o = r_count != 2'd0;
    assign data_o  = r_slot0;
    assign count_o = r_count;
endmodule

// File: rtl/fifo_sram_pop_stream.sv
// fifo_sram_pop_stream: pops a 1-cycle-latency BRAM FIFO and presents its words as a valid/ready stream
module fifo_sram_pop_stream
    import fifo_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HOLDOFF    = HOLDOFF_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  holdoff_o,
    output logic [1:0]            count_o
);
    localparam int HW = holdoff_width(HOLDOFF);

    logic [HW-1:0] r_holdoff_cnt, w_holdoff_nxt;
    logic          r_holdoff, r_inflight, w_drain;
    logic [2:0]    w_owned;

    always_comb begin
        w_holdoff_nxt = flush_i ? HW'(HOLDOFF)
                                : (r_holdoff_cnt != '0 ? r_holdoff_cnt - 1'b1 : r_holdoff_cnt);
        w_drain       = valid_o && ready_i;
        // a word popped now is only accepted if buffered + in flight + it still fits in two slots
        w_owned       = {1'b0, count_o} + {2'b0, r_inflight} + {2'b0, !w_drain};
        fifo_pop_o    = !r_holdoff && !fifo_empty_i && !flush_i && w_owned <= 3'd2;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_holdoff_cnt <= HW'(HOLDOFF);
            r_holdoff     <= 1'b1;
            r_inflight    <= 1'b0;
        end else begin
            r_holdoff_cnt <= w_holdoff_nxt;
            r_holdoff     <= w_holdoff_nxt != '0;
            r_inflight    <= fifo_pop_o;
        end
    end

    stream_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (r_inflight),
        .data_i  (fifo_data_i),
        .pop_i   (w_drain),
        .valid_o (valid_o),
        .data_o  (data_o),
        .count_o (count_o)
    );

    assign holdoff_o = r_holdoff;
endmodule
